// File: rtl/redirect_ctl_pkg.sv
// ============================================================================
// Module      : redirect_ctl_pkg
// Description : Shared types for the front-end redirect sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package redirect_ctl_pkg;

    localparam int c_drain_w = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        SRC_BJ   = 1'b0,
        SRC_TRAP = 1'b1
    } src_t;

endpackage

`default_nettype wire

// File: rtl/redirect_drain_cnt.sv
// ============================================================================
// Module      : redirect_drain_cnt
// Description : Loadable down-counter with zero flag; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module redirect_drain_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/redirect_ctl.sv
// ============================================================================
// Module      : redirect_ctl
// Description : Arbitrates branch/trap redirects, hands the target to fetch
//               and squashes stale fetch responses for a drain window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module redirect_ctl
    import redirect_ctl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             bj_en,
    input  logic [XLEN-1:0]  bj_pc,
    input  logic             trap_en,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             squash_fetch,
    output logic             busy,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [c_drain_w-1:0] c_drain_load = c_drain_w'(DRAIN_CYCLES);
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(1);

    state_t               r_state, w_state_nxt;
    logic [XLEN-1:0]      r_pc, w_pc_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 w_req;
    src_t                 w_src;
    logic [XLEN-1:0]      w_sel_pc;
    logic                 w_load;
    logic                 w_dec;
    logic [c_drain_w-1:0] w_drain_cnt;
    logic                 w_drain_zero;

    // Traps are never gated by stall; branches from a stalled EX are not yet real.
    assign w_req    = trap_en | (bj_en & ~stall);
    assign w_src    = trap_en ? SRC_TRAP : SRC_BJ;
    assign w_sel_pc = (w_src == SRC_TRAP) ? trap_pc : bj_pc;

    redirect_drain_cnt #(
        .WIDTH (c_drain_w)
    ) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_drain_load),
        .i_dec      (w_dec),
        .o_count    (w_drain_cnt),
        .o_zero     (w_drain_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_pc_nxt    = w_sel_pc;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                // A trap replaces the offered target and cancels a same-cycle accept;
                // a branch here is wrong-path and ignored.
                if (trap_en) begin
                    w_pc_nxt = trap_pc;
                end else if (fetch_ready) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_req) begin
                    w_pc_nxt    = w_sel_pc;
                    w_state_nxt = ST_PEND;
                end else begin
                    w_dec = 1'b1;
                    if (w_drain_zero || (w_drain_cnt == c_drain_last)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign redirect_valid = (r_state == ST_PEND);
    assign redirect_pc    = r_pc;
    assign flush          = (r_state != ST_IDLE);
    assign squash_fetch   = (r_state == ST_DRAIN);
    assign busy           = (r_state != ST_IDLE);
    assign redirect_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_redirect_ctl.sv
// ============================================================================
// Module      : tb_redirect_ctl
// Description : Self-checking bench: two instances (drain 2 and drain 0)
//               against a behavioural model, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_redirect_ctl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;
    localparam int D0    = 2;
    localparam int D1    = 0;

    logic            clk = 1'b0;
    logic            rst, stall, bj_en, trap_en, fetch_ready;
    logic [XLEN-1:0] bj_pc, trap_pc;

    logic             rv   [2];
    logic [XLEN-1:0]  rpc  [2];
    logic             fl   [2];
    logic             sq   [2];
    logic             bs   [2];
    logic [CNT_W-1:0] rcnt [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit sq1_seen = 1'b0;

    // Model: pending flag, target, remaining drain cycles, accepted count.
    bit               m_pend  [2];
    logic [XLEN-1:0]  m_pc    [2];
    int               m_drain [2];
    logic [CNT_W-1:0] m_cnt   [2];

    always #5 clk = ~clk;

    redirect_ctl #(.XLEN(XLEN), .DRAIN_CYCLES(D0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .bj_en(bj_en), .bj_pc(bj_pc),
        .trap_en(trap_en), .trap_pc(trap_pc), .fetch_ready(fetch_ready),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .flush(fl[0]),
        .squash_fetch(sq[0]), .busy(bs[0]), .redirect_cnt(rcnt[0])
    );

    redirect_ctl #(.XLEN(XLEN), .DRAIN_CYCLES(D1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .bj_en(bj_en), .bj_pc(bj_pc),
        .trap_en(trap_en), .trap_pc(trap_pc), .fetch_ready(fetch_ready),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .flush(fl[1]),
        .squash_fetch(sq[1]), .busy(bs[1]), .redirect_cnt(rcnt[1])
    );

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    function automatic int dlen(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pend[i]  = 1'b0;
                m_pc[i]    = '0;
                m_drain[i] = 0;
                m_cnt[i]   = '0;
            end else if (m_pend[i]) begin
                if (trap_en) begin
                    m_pc[i] = trap_pc;
                end else if (fetch_ready) begin
                    m_cnt[i]   = m_cnt[i] + 1;
                    m_pend[i]  = 1'b0;
                    m_drain[i] = dlen(i);
                end
            end else if (trap_en || (bj_en && !stall)) begin
                m_pend[i]  = 1'b1;
                m_pc[i]    = trap_en ? trap_pc : bj_pc;
                m_drain[i] = 0;
            end else if (m_drain[i] > 0) begin
                m_drain[i] = m_drain[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("redirect_valid", i, 64'(rv[i]), 64'(m_pend[i]));
                chk("redirect_pc",    i, rpc[i], m_pc[i]);
                chk("flush",          i, 64'(fl[i]), 64'(m_pend[i] || m_drain[i] > 0));
                chk("squash_fetch",   i, 64'(sq[i]), 64'(!m_pend[i] && m_drain[i] > 0));
                chk("busy",           i, 64'(bs[i]), 64'(m_pend[i] || m_drain[i] > 0));
                chk("redirect_cnt",   i, 64'(rcnt[i]), 64'(m_cnt[i]));
            end
            if (sq[1]) sq1_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; bj_en = 0; trap_en = 0; fetch_ready = 0;
    endtask

    initial begin
        rst = 1'b1; bj_pc = '0; trap_pc = '0;
        idle_inputs();
        tick();
        chk_en = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 64'(rv[i]), 64'd0);
            chk("rst_pc",    i, rpc[i], 64'd0);
            chk("rst_busy",  i, 64'(bs[i]), 64'd0);
            chk("rst_cnt",   i, 64'(rcnt[i]), 64'd0);
        end
        rst = 1'b0;

        // Basic redirect: request in cycle 0, accept in cycle 2.
        bj_en = 1; bj_pc = 64'h8000_0100;
        tick();
        bj_en = 0;
        chk("t1_valid_c1", 0, 64'(rv[0]), 64'd1);
        chk("t1_pc_c1",    0, rpc[0], 64'h8000_0100);
        tick();
        fetch_ready = 1;
        chk("t1_valid_c2", 0, 64'(rv[0]), 64'd1);
        tick();
        fetch_ready = 0;
        chk("t1_squash_c3", 0, 64'(sq[0]), 64'd1);
        chk("t1_cnt",       0, 64'(rcnt[0]), 64'd1);
        chk("t1_d0_idle",   1, 64'(bs[1]), 64'd0);
        tick();
        chk("t1_squash_c4", 0, 64'(sq[0]), 64'd1);
        tick();
        chk("t1_idle_c5", 0, 64'(bs[0]), 64'd0);

        // Stall gating.
        bj_en = 1; stall = 1; bj_pc = 64'h4444;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_stalled_busy", 0, 64'(bs[0]), 64'd0);
        end
        stall = 0;
        tick();
        bj_en = 0; fetch_ready = 1;
        chk("t2_valid", 0, 64'(rv[0]), 64'd1);
        tick();
        idle_inputs();
        repeat (3) tick();

        // Same-cycle priority.
        bj_en = 1; bj_pc = 64'h1000; trap_en = 1; trap_pc = 64'h8000_0000;
        tick();
        idle_inputs();
        chk("t3_pc", 0, rpc[0], 64'h8000_0000);
        fetch_ready = 1;
        tick();
        idle_inputs();
        repeat (3) tick();

        // Trap overrides pending target.
        bj_en = 1; bj_pc = 64'h1000;
        tick();
        bj_en = 0; trap_en = 1; trap_pc = 64'h2000; fetch_ready = 1;
        tick();
        trap_en = 0;
        chk("t4_pc",  0, rpc[0], 64'h2000);
        chk("t4_cnt_held", 0, 64'(rcnt[0]), 64'd3);
        tick();
        fetch_ready = 0;
        chk("t4_cnt", 0, 64'(rcnt[0]), 64'd4);
        repeat (3) tick();

        // Restart during the first drain cycle.
        bj_en = 1; bj_pc = 64'h4000;
        tick();
        bj_en = 0; fetch_ready = 1;
        tick();
        fetch_ready = 0; bj_en = 1; bj_pc = 64'h3000;
        chk("t5_drain", 0, 64'(sq[0]), 64'd1);
        tick();
        bj_en = 0;
        chk("t5_valid", 0, 64'(rv[0]), 64'd1);
        chk("t5_pc",    0, rpc[0], 64'h3000);
        fetch_ready = 1;
        tick();
        fetch_ready = 0;
        chk("t5_cnt",     0, 64'(rcnt[0]), 64'd6);
        chk("t5_reload1", 0, 64'(sq[0]), 64'd1);
        tick();
        chk("t5_reload2", 0, 64'(sq[0]), 64'd1);
        tick();
        chk("t5_idle", 0, 64'(bs[0]), 64'd0);

        // Reset while pending.
        bj_en = 1; bj_pc = 64'h5000;
        tick();
        bj_en = 0;
        chk("t6_pend", 0, 64'(rv[0]), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_valid", 0, 64'(rv[0]), 64'd0);
        chk("t6_flush", 0, 64'(fl[0]), 64'd0);
        chk("t6_pc",    0, rpc[0], 64'd0);
        chk("t6_cnt",   0, 64'(rcnt[0]), 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            bj_en       = ($urandom_range(0, 9) < 3);
            trap_en     = ($urandom_range(0, 9) == 0);
            fetch_ready = ($urandom_range(0, 1) == 1);
            bj_pc       = {$urandom, $urandom};
            trap_pc     = {$urandom, $urandom};
            tick();
        end
        idle_inputs(); rst = 0;
        repeat (4) tick();

        chk("d0_never_squash", 1, 64'(sq1_seen), 64'd0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/redirect_ctl.md
Name: redirect_ctl

Overview:
- Sequences every front-end redirect in the core.
- Captures branch/jump redirects from the execute-stage jump/branch unit and trap redirects from the CSR/trap unit, and arbitrates between them (trap wins).
- Holds the chosen target until fetch accepts it, then squashes stale in-flight fetch responses for a fixed drain window.
- Sits between execute/CSR and the fetch stage; drives the IF/ID flush.

Parameters:
XLEN, 64, PC and target width (matches `XLEN)
DRAIN_CYCLES, 2, cycles of fetch-response squash after fetch accepts a redirect (0..15)
CNT_W, 32, width of the redirect performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
stall  in  1  execute stage stalled this cycle
bj_en  in  1  jump/branch unit requests redirect
bj_pc  in  XLEN  jump/branch target
trap_en  in  1  trap/xret redirect request
trap_pc  in  XLEN  trap/xret target
fetch_ready  in  1  fetch accepts a new PC this cycle
redirect_valid  out  1  redirect target offered to fetch
redirect_pc  out  XLEN  redirect target
flush  out  1  kill IF/ID contents and block ID->EX issue
squash_fetch  out  1  discard fetch responses returning this cycle
busy  out  1  state != IDLE
redirect_cnt  out  CNT_W  number of redirects accepted by fetch (wraps)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, squash_fetch=0, busy=0, redirect_cnt=0, drain counter=0. rst takes effect mid-operation too; a pending redirect is discarded.
- Request qualification:
  - bj request = bj_en & ~stall.
  - trap request = trap_en; stall does not gate it.
- Arbitration in a single cycle: trap > bj. Selected target = trap_pc if trap request, else bj_pc.
- States: IDLE, PEND, DRAIN.
- IDLE:
  - On any qualified request at edge N, register the target. From cycle N+1: state=PEND, redirect_valid=1, flush=1.
  - Latency is exactly one cycle; no combinational path from inputs to outputs.
- PEND:
  - redirect_valid=1, flush=1, redirect_pc held stable.
  - Handshake: accepted when redirect_valid & fetch_ready at a clk edge. redirect_cnt increments by 1 (wraps at 2^CNT_W).
  - After acceptance: go to DRAIN with counter=DRAIN_CYCLES; if DRAIN_CYCLES=0, go to IDLE.
  - trap_en in PEND (including the accept cycle): overwrite redirect_pc with trap_pc and stay in PEND. The accept is cancelled and redirect_cnt does not increment.
  - bj_en in PEND is ignored, because it comes from a wrong-path instruction.
- DRAIN:
  - redirect_valid=0, flush=1, squash_fetch=1. Counter decrements each cycle; at 1->0 go to IDLE.
  - A qualified request in DRAIN (trap or bj) restarts: capture the target and go to PEND next cycle, same arbitration.
- flush=0 and squash_fetch=0 in IDLE.
- busy = (state != IDLE).
- Targets pass through unmodified; alignment is the producer's responsibility.

Decomposition:
- Shared package: state enum (IDLE/PEND/DRAIN) as a 2-bit typedef, and a redirect-source enum (SRC_BJ, SRC_TRAP) for debug/trace.
- One sub-module: redirect_drain_cnt, a loadable down-counter with a zero flag, reusable by other flush paths.
- Everything else lives in one always block plus output assigns.

Test Plan:
1. Basic redirect:
   - Stimulus: bj_en=1, stall=0, bj_pc=0x8000_0100 at cycle 0; fetch_ready=1 at cycle 2.
   - Response: cycles 1-2 redirect_valid=1 and redirect_pc=0x8000_0100; cycles 3-4 squash_fetch=1; IDLE at cycle 5; redirect_cnt=1.
2. Stall gating:
   - Stimulus: bj_en=1 with stall=1 for 3 cycles, then stall=0.
   - Response: no output activity during the stall; redirect_valid asserts in the cycle after stall drops.
3. Same-cycle priority:
   - Stimulus: bj_en=1 (bj_pc=0x1000) and trap_en=1 (trap_pc=0x8000_0000) in the same cycle.
   - Response: redirect_pc=0x8000_0000; bj target never appears.
4. Trap overrides pending:
   - Stimulus: in PEND with 0x1000 and fetch_ready=0, pulse trap_en with trap_pc=0x2000.
   - Response: redirect_pc=0x2000 next cycle; after acceptance redirect_cnt increments once only.
5. Restart in DRAIN:
   - Stimulus: bj_en=1 (0x3000) during the first DRAIN cycle.
   - Response: PEND next cycle with redirect_pc=0x3000; drain counter reloads after the new accept.
6. Reset mid-PEND, plus DRAIN_CYCLES=0 variant:
   - Stimulus (a): assert rst while in PEND. Response (a): all outputs 0 next cycle; redirect_cnt=0.
   - Stimulus (b): DRAIN_CYCLES=0, accept a redirect. Response (b): IDLE the cycle after accept; squash_fetch is never asserted.
